// File: rtl/fifo_rd_streamer_pkg.sv
// Shared types and sizing helpers for the FIFO read streamer.
// FIFO_STREAM_STATS_EN (in the top) adds the saturating pop counter.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 8;

    // Wide enough to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus valid/ready output stream of the read streamer.
// master = streamer side, slave = FIFO + consumer side.
interface fifo_rd_streamer_if
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_cs;
    logic              fifo_rd_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_cs, fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_cs, fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rd_streamer_skid_buf.sv
// Circular skid buffer absorbing the FIFO read latency.
// Any depth >= 2 is legal; pointers wrap at SKID_DEPTH-1.
module fifo_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SKID_DEPTH = 3,
    localparam int OW        = occ_w(SKID_DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [OW-1:0]     occ_o
);
    logic [DATA_W-1:0] mem_q [SKID_DEPTH];
    logic [OW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;

    function automatic logic [OW-1:0] ptr_inc(input logic [OW-1:0] p);
        return (p == OW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (wr_i && !rd_i)
            occ_d = occ_q + 1'b1;
        else if (!wr_i && rd_i)
            occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SKID_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_i)
                mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side streamer: credit-based pop, skid buffer, valid/ready out.
// Define FIFO_STREAM_STATS_EN to add the saturating pop_count output.
module fifo_rd_streamer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SKID_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    output logic                  busy,
    fifo_rd_streamer_if.master    bus
`ifdef FIFO_STREAM_STATS_EN
    ,
    output logic [CNT_W-1:0]      pop_count
`endif
);
    localparam int OW = occ_w(SKID_DEPTH);

    if (SKID_DEPTH < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("fifo_rd_streamer: SKID_DEPTH must be >= 2, CNT_W >= 1");
    end

    state_e            state_q, state_d;
    logic              inflight_q;
    logic [OW-1:0]     occ;
    logic [OW:0]       credit_used;
    logic [DATA_W-1:0] head;
    logic              rd_en;
    logic              xfer;

    // Credits count both buffered words and the one still in flight.
    assign credit_used = {1'b0, occ} + {{OW{1'b0}}, inflight_q};
    assign rd_en = (state_q == RUN) && !bus.fifo_empty &&
                   (credit_used < (OW + 1)'(SKID_DEPTH));
    assign xfer  = (occ != '0) && bus.m_ready;

    fifo_skid_buf #(
        .DATA_W     (DATA_W),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .resetn  (resetn),
        .wr_i    (inflight_q),
        .wdata_i (bus.fifo_data),
        .rd_i    (xfer),
        .rdata_o (head),
        .occ_o   (occ)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (enable) state_d = RUN;
            RUN:   if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)
                    state_d = RUN;
                else if (occ == '0 && !inflight_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_rd_cs = (state_q != IDLE);
        bus.fifo_rd_en = rd_en;
        bus.m_valid    = (occ != '0);
        bus.m_data     = head;
        busy           = (state_q != IDLE);
    end

`ifdef FIFO_STREAM_STATS_EN
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (rd_en && !(&pop_cnt_q))
            pop_cnt_d = pop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pop_cnt_q <= '0;
        else
            pop_cnt_q <= pop_cnt_d;
    end

    assign pop_count = pop_cnt_q;
`endif
endmodule
